pipe_ctrl_unit: RTL

//   Parametrised pipeline control unit for the N-stage core. Arbitrates per-stage stall requests,

---
 rtl/pipe_ctrl_unit_pkg.sv | 46 ++++
 rtl/pipe_ctrl_unit_if.sv | 21 ++
 rtl/pipe_ctrl_unit_stall_mask_gen.sv | 23 ++
 rtl/pipe_ctrl_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared definitions for the pipeline control unit: exception codes,
// flush-cause values, FSM state encoding and the exception vector helper.
package pipe_ctrl_unit_pkg;

    // Exception / ERET codes carried on exception_type_i
    localparam logic [4:0] EXCEPTION_INT  = 5'h00;
    localparam logic [4:0] EXCEPTION_ADEL = 5'h04;
    localparam logic [4:0] EXCEPTION_ADES = 5'h05;
    localparam logic [4:0] EXCEPTION_SYS  = 5'h08;
    localparam logic [4:0] EXCEPTION_BP   = 5'h09;
    localparam logic [4:0] EXCEPTION_RI   = 5'h0a;
    localparam logic [4:0] EXCEPTION_OV   = 5'h0c;
    localparam logic [4:0] EXCEPTION_TR   = 5'h0d;
    localparam logic [4:0] EXCEPTION_ERET = 5'h1f;

    // Reason reported alongside flush_o
    typedef enum logic {
        FLUSH_CAUSE_EXC     = 1'b0,
        FLUSH_CAUSE_MISPRED = 1'b1
    } flush_cause_e;

    // FSM state encoding, kept as plain constants so older blocks can share it
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_FLUSH    = 2'd1;
    localparam state_t ST_REDIRECT = 2'd2;

    // Fetch target for a committed exception: the vector for real traps,
    // the saved EPC for ERET, and zero for codes the core does not define.
    function automatic logic [31:0] exc_target(input logic [4:0]  exc_type,
                                               input logic [31:0] ebase,
                                               input logic [31:0] epc);
        logic [31:0] target;
        case (exc_type)
            EXCEPTION_INT, EXCEPTION_ADEL, EXCEPTION_ADES, EXCEPTION_SYS,
            EXCEPTION_BP, EXCEPTION_RI, EXCEPTION_OV, EXCEPTION_TR:
                target = ebase;
            EXCEPTION_ERET:
                target = epc;
            default:
                target = 32'h0000_0000;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Redirect handshake between the pipeline control unit (master) and fetch (slave).
interface pipe_ctrl_unit_if;
    import pipe_ctrl_unit_pkg::*;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );

endinterface

// File: rtl/pipe_ctrl_unit_stall_mask_gen.sv
// Priority encoder plus thermometer mask: for the highest set request bit h
// the mask has bits [h:0] set, so every older stage freezes behind it.
module stall_mask_gen
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0] i_req,
    output logic [W-1:0] o_mask,
    output logic         o_any
);

    // A stage is frozen when it or any younger-index-above stage requested a stall
    always_comb begin
        o_mask = '0;
        for (int k = 0; k < W; k++) begin
            o_mask[k] = |(i_req >> k);
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: arbitrates stalls, mispredict flushes and exceptions,
// drives per-stage stall/flush, issues the redirect PC to fetch, and keeps a
// stall watchdog plus saturating stall/flush counters.
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int NUM_STAGES    = 5,
    parameter int MISPRED_STAGE = 3,
    parameter int FLUSH_CYCLES  = 1,
    parameter int WDOG_LIMIT    = 1024,
    parameter int CNT_W         = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_STAGES-1:0] stallreq_i,
    input  logic                  pred_fail_i,
    input  logic [31:0]           pred_target_i,
    input  logic                  exception_flag_i,
    input  logic [4:0]            exception_type_i,
    input  logic [31:0]           cp0_epc_i,
    input  logic [31:0]           ebase_i,
    pipe_ctrl_unit_if.master      redir,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic                  flush_o,
    output logic                  flush_cause_o,
    output logic                  flush_to_ibuffer_o,
    output logic                  stall_timeout_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam int              CW       = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_INIT = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [31:0]     WDOG_L   = 32'(WDOG_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [31:0]           r_pc;
    logic                  r_valid;
    logic [31:0]           r_run;
    logic                  r_timeout;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;

    state_t                w_next_state;
    logic [CW-1:0]         w_next_cnt;
    logic [31:0]           w_next_pc;
    logic [NUM_STAGES-1:0] w_stall;
    logic                  w_flush;
    logic                  w_cause;
    logic                  w_accept;

    logic [NUM_STAGES-1:0] w_hi_sel;
    logic [NUM_STAGES-1:0] w_hi_req;
    logic [NUM_STAGES-1:0] w_lo_req;
    logic [NUM_STAGES-1:0] w_hi_mask;
    logic [NUM_STAGES-1:0] w_lo_mask;
    logic                  w_hi_any;
    logic                  w_lo_any;

    // Split requests into the group that outranks a mispredict and the group that loses to it
    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_sel
        assign w_hi_sel[g] = (g >= MISPRED_STAGE);
    end

    assign w_hi_req = stallreq_i & w_hi_sel;
    assign w_lo_req = stallreq_i & ~w_hi_sel;

    stall_mask_gen #(.W(NUM_STAGES)) u_hi_mask (
        .i_req  (w_hi_req),
        .o_mask (w_hi_mask),
        .o_any  (w_hi_any)
    );

    stall_mask_gen #(.W(NUM_STAGES)) u_lo_mask (
        .i_req  (w_lo_req),
        .o_mask (w_lo_mask),
        .o_any  (w_lo_any)
    );

    // Arbitration and next-state logic; exceptions win everywhere except during an active flush
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_pc    = r_pc;
        w_stall      = '0;
        w_flush      = 1'b0;
        w_cause      = FLUSH_CAUSE_EXC;
        w_accept     = 1'b0;

        if (exception_flag_i && (r_state != ST_FLUSH)) begin
            w_flush   = 1'b1;
            w_accept  = 1'b1;
            w_next_pc = exc_target(exception_type_i, ebase_i, cp0_epc_i);
            if (FLUSH_CYCLES > 1) begin
                w_next_state = ST_FLUSH;
                w_next_cnt   = CNT_INIT;
            end else begin
                w_next_state = ST_REDIRECT;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hi_any) begin
                        w_stall = w_hi_mask;
                    end else if (pred_fail_i) begin
                        w_flush      = 1'b1;
                        w_cause      = FLUSH_CAUSE_MISPRED;
                        w_accept     = 1'b1;
                        w_next_pc    = pred_target_i;
                        w_next_state = ST_REDIRECT;
                    end else if (w_lo_any) begin
                        w_stall = w_lo_mask;
                    end
                end
                ST_FLUSH: begin
                    w_flush = 1'b1;
                    if (r_cnt <= CNT_ONE) begin
                        w_next_cnt   = '0;
                        w_next_state = ST_REDIRECT;
                    end else begin
                        w_next_cnt = r_cnt - CNT_ONE;
                    end
                end
                ST_REDIRECT: begin
                    if (redir.redirect_ready) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // FSM, pending redirect PC and the registered valid that follows the REDIRECT state
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_pc    <= w_next_pc;
            r_valid <= (w_next_state == ST_REDIRECT);
        end
    end

    // Saturating performance counters for stalled cycles and accepted flushes
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((|w_stall) && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_accept && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    // Watchdog: count consecutive stalled cycles and latch the timeout once the run hits the limit
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_run     <= '0;
            r_timeout <= 1'b0;
        end else if (WDOG_LIMIT == 0) begin
            r_run <= '0;
        end else if (|w_stall) begin
            if (r_run < WDOG_L) begin
                r_run <= r_run + 32'd1;
            end
            if (r_run >= (WDOG_L - 32'd1)) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_run <= '0;
        end
    end

    assign stall_o            = resetn ? w_stall : '0;
    assign flush_o            = resetn & w_flush;
    assign flush_cause_o      = resetn & w_cause;
    assign flush_to_ibuffer_o = !resetn | flush_o;

    assign redir.redirect_valid = r_valid;
    assign redir.redirect_pc    = r_pc;

    assign stall_timeout_o = r_timeout;
    assign stall_cnt_o     = r_stall_cnt;
    assign flush_cnt_o     = r_flush_cnt;

endmodule
